video_out_stage: RTL
====================

Name: video_out_stage

Overview:
- Parametrised successor to the fixed 6/7-stage timing delay and blanked RGB register in the top level.
- Sits between the vga timing generator plus pixel generator (e.g. track_view) and the VGA pins.
- Delays timing by a configurable pixel latency, registers RGB with blanking and configurable sync polarity, and suppresses output until the pipeline is primed.
- Adds a frame counter and a new-frame pulse for game logic.

Parameters:
H_WIDTH, 11, width of hcount.
V_WIDTH, 10, width of vcount.
COLOR_BITS, 4, bits per colour channel; pixel_in is 3*COLOR_BITS wide as {r,g,b}.
PIX_LATENCY, 6, cycles from hcount_in to the matching pixel_in; legal range 1..15.
BLANK_COLOR, 0, 3*COLOR_BITS value driven on RGB while blanked or unprimed.
SYNC_ACTIVE_LOW, 1, 1 means pin sync = inverted internal active-high sync.

Ports:
clk_in  input  1  pixel clock (65 MHz).
rst_in  input  1  synchronous reset, active-low.
hcount_in  input  H_WIDTH  pixel on line, from vga.
vcount_in  input  V_WIDTH  line number, from vga.
hsync_in  input  1  active-high hsync, from vga.
vsync_in  input  1  active-high vsync, from vga.
blank_in  input  1  active-high blank, from vga.
pixel_in  input  3*COLOR_BITS  pixel matching the timing from PIX_LATENCY cycles earlier.
hcount_aligned_out  output  H_WIDTH  hcount_in delayed PIX_LATENCY (aligned to pixel_in).
vcount_aligned_out  output  V_WIDTH  vcount_in delayed PIX_LATENCY.
vga_r, vga_g, vga_b  output  COLOR_BITS each  registered colour.
vga_hs, vga_vs  output  1 each  sync at pin polarity.
frame_count_out  output  16  completed-frame count.
new_frame_out  output  1  one-cycle pulse per frame.
primed_out  output  1  high once the pipeline is filled.

Behaviour:
- Reset is synchronous and active-low: on the clock edge with rst_in==0, clear all state.
  - Pipe stages: blank=1, syncs=0, counts=0.
  - vga_r/g/b = BLANK_COLOR.
  - vga_hs/vga_vs = inactive level (1 when SYNC_ACTIVE_LOW).
  - frame_count_out=0, new_frame_out=0, primed_out=0, aligned counts=0.
- Timing pipe: PIX_LATENCY+1 register stages for hcount, vcount, hsync, vsync and blank. Stage k holds the input delayed k cycles.
- Aligned outputs = stage PIX_LATENCY.
- RGB register: at each edge, rgb <= (stage PIX_LATENCY blank | !primed) ? BLANK_COLOR : pixel_in.
  - Total latency from timing input to RGB pin = PIX_LATENCY+1.
- Sync outputs:
  - Source is stage PIX_LATENCY+1 sync, so syncs align exactly with RGB.
  - Polarity is applied per SYNC_ACTIVE_LOW.
  - Forced inactive while !primed.
- Priming:
  - A fill counter (4-5 bits) counts clocks after reset release.
  - primed_out goes high on the cycle the counter reaches PIX_LATENCY+1, then saturates.
  - First non-forced RGB/sync appears on the next edge.
- Frame count:
  - Edge detect the rising edge of the stage PIX_LATENCY+1 internal vsync while primed.
  - On that edge: frame_count_out increments by 1, wrapping 16'hFFFF -> 0, and new_frame_out=1 for exactly that cycle. Otherwise new_frame_out=0.
  - A vsync already high at priming does not count; a 0->1 transition is required.
- Reset mid-frame: everything reverts to reset values the next edge, and priming restarts.
- Widths: no arithmetic on the colour path; pixel_in bit slices are [3C-1:2C] r, [2C-1:C] g, [C-1:0] b.

Optional Feature:
- Macro: VIDEO_OUT_TESTPAT_EN.
- Defined:
  - Adds input testpat_in (1 bit).
  - When high, pixel_in is replaced by an 8-bar colour pattern from hcount_aligned bits [H_WIDTH-2:H_WIDTH-4] (bars of 128 px at 11-bit hcount).
  - Bar index i gives r=all(i[2]), g=all(i[1]), b=all(i[0]).
  - Blanking and priming still override the pattern.
- Undefined: port absent; pixel_in is always used.

Test Plan:
- Reset hold then release, PIX_LATENCY=6 -> vga_r/g/b=0 and vga_hs=vga_vs=1 for 7 cycles; primed_out rises on cycle 7.
- After priming, drive hcount_in=100, blank_in=0, then pixel_in=12'hABC 6 cycles later -> hcount_aligned_out=100 on that cycle; vga_r=A, vga_g=B, vga_b=C one cycle later.
- blank_in=1 with pixel_in=12'hFFF -> RGB=BLANK_COLOR exactly PIX_LATENCY+1 cycles after blank_in, with no early or late pixel.
- hsync_in pulse of 136 cycles -> vga_hs low for exactly 136 cycles, starting 7 cycles later; SYNC_ACTIVE_LOW=0 gives a high pulse.
- Three vsync pulses, then preload near wrap (run 65536 frames or force) -> frame_count_out 0->1->2->3; 16'hFFFF->0 with new_frame_out a single-cycle pulse each time.
- Assert rst_in low mid-line, then release -> outputs return to reset values on the next edge, primed_out=0, frame_count_out=0, and re-priming takes 7 cycles.

Source files
------------

// File: rtl/video_out_stage.sv
// Output stage between the pixel pipeline and the VGA pins: delays timing,
// blanks and registers RGB, sets sync polarity, counts frames. Option: VIDEO_OUT_TESTPAT_EN.
module video_out_stage #(
    parameter int                      H_WIDTH         = 11,
    parameter int                      V_WIDTH         = 10,
    parameter int                      COLOR_BITS      = 4,
    parameter int                      PIX_LATENCY     = 6,
    parameter logic [3*COLOR_BITS-1:0] BLANK_COLOR     = '0,
    parameter bit                      SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [H_WIDTH-1:0]        hcount_in,
    input  logic [V_WIDTH-1:0]        vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [3*COLOR_BITS-1:0]   pixel_in,
`ifdef VIDEO_OUT_TESTPAT_EN
    input  logic                      testpat_in,
`endif
    output logic [H_WIDTH-1:0]        hcount_aligned_out,
    output logic [V_WIDTH-1:0]        vcount_aligned_out,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      vga_hs,
    output logic                      vga_vs,
    output logic [15:0]               frame_count_out,
    output logic                      new_frame_out,
    output logic                      primed_out
);

    localparam int         PW        = 3 * COLOR_BITS;
    localparam int         L         = PIX_LATENCY;
    localparam logic [4:0] FILL_LAST = 5'(PIX_LATENCY);
    localparam logic       SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic [H_WIDTH-1:0] hc_pipe [1:L];
    logic [V_WIDTH-1:0] vc_pipe [1:L];
    logic               hs_pipe [1:L];
    logic               vs_pipe [1:L];
    logic               bl_pipe [1:L];
    logic               vs_s;

    logic [4:0]         fill_cnt;
    logic               primed;
    logic [PW-1:0]      rgb_q;
    logic               hs_pin;
    logic               vs_pin;
    logic [15:0]        frame_cnt;
    logic               new_frame;
    logic [PW-1:0]      pix_src;
    logic               vs_rise;

`ifdef VIDEO_OUT_TESTPAT_EN
    logic [2:0] bar;
    assign bar = hc_pipe[L][H_WIDTH-2:H_WIDTH-4];

    always_comb begin
        pix_src = pixel_in;
        if (testpat_in) begin
            pix_src = {{COLOR_BITS{bar[2]}},
                       {COLOR_BITS{bar[1]}},
                       {COLOR_BITS{bar[0]}}};
        end
    end
`else
    assign pix_src = pixel_in;
`endif

    // Timing delay line; vs_s is the unblanked stage L+1 vsync for edge detect.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 1; k <= L; k++) begin
                hc_pipe[k] <= '0;
                vc_pipe[k] <= '0;
                hs_pipe[k] <= 1'b0;
                vs_pipe[k] <= 1'b0;
                bl_pipe[k] <= 1'b1;
            end
            vs_s <= 1'b0;
        end else begin
            hc_pipe[1] <= hcount_in;
            vc_pipe[1] <= vcount_in;
            hs_pipe[1] <= hsync_in;
            vs_pipe[1] <= vsync_in;
            bl_pipe[1] <= blank_in;
            for (int k = 2; k <= L; k++) begin
                hc_pipe[k] <= hc_pipe[k-1];
                vc_pipe[k] <= vc_pipe[k-1];
                hs_pipe[k] <= hs_pipe[k-1];
                vs_pipe[k] <= vs_pipe[k-1];
                bl_pipe[k] <= bl_pipe[k-1];
            end
            vs_s <= vs_pipe[L];
        end
    end

    assign vs_rise = primed & vs_pipe[L] & ~vs_s;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fill_cnt  <= '0;
            primed    <= 1'b0;
            rgb_q     <= BLANK_COLOR;
            hs_pin    <= SYNC_IDLE;
            vs_pin    <= SYNC_IDLE;
            frame_cnt <= '0;
            new_frame <= 1'b0;
        end else begin
            if (!primed) begin
                fill_cnt <= fill_cnt + 5'd1;
            end
            if (fill_cnt == FILL_LAST) begin
                primed <= 1'b1;
            end
            rgb_q     <= (bl_pipe[L] | ~primed) ? BLANK_COLOR : pix_src;
            hs_pin    <= (hs_pipe[L] & primed) ^ SYNC_ACTIVE_LOW;
            vs_pin    <= (vs_pipe[L] & primed) ^ SYNC_ACTIVE_LOW;
            new_frame <= vs_rise;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign hcount_aligned_out = hc_pipe[L];
    assign vcount_aligned_out = vc_pipe[L];
    assign vga_r              = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vga_g              = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign vga_b              = rgb_q[COLOR_BITS-1:0];
    assign vga_hs             = hs_pin;
    assign vga_vs             = vs_pin;
    assign frame_count_out    = frame_cnt;
    assign new_frame_out      = new_frame;
    assign primed_out         = primed;

endmodule
